// File: rtl/counter_scheduler_if.sv
// counter_scheduler_if: requester handshakes plus shared-counter control bus.
interface counter_scheduler_if #(parameter int WIDTH = 4);
  logic             req_a, req_b, dir_a, dir_b;
  logic [WIDTH-1:0] start_a, start_b, steps_a, steps_b;
  logic             gnt_a, gnt_b, done_a, done_b, busy;
  logic [WIDTH-1:0] result;
  logic             cnt_clr, cnt_load, cnt_up_down;
  logic [WIDTH-1:0] cnt_data, cnt_value;
  modport master (
    input  req_a, req_b, dir_a, dir_b, start_a, start_b, steps_a, steps_b, cnt_value,
    output gnt_a, gnt_b, done_a, done_b, busy, result, cnt_clr, cnt_load, cnt_up_down, cnt_data
  );
  modport slave (
    output req_a, req_b, dir_a, dir_b, start_a, start_b, steps_a, steps_b, cnt_value,
    input  gnt_a, gnt_b, done_a, done_b, busy, result, cnt_clr, cnt_load, cnt_up_down, cnt_data
  );
endinterface

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin arbiter handing one enable-less up/down counter to two requesters.
module counter_scheduler #(parameter int WIDTH = 4) (
  input logic              clk,
  input logic              reset,
  counter_scheduler_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0]       state;
  logic             owner_b, prio_b, dir, pick_b, gnt_a, gnt_b, done_a, done_b;
  logic [WIDTH-1:0] start, rem, result;
  // prio_b marks B as the favoured requester on a tie; cleared after reset so A wins first
  assign pick_b = bus.req_b & (~bus.req_a | prio_b);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      owner_b <= 1'b0;
      prio_b  <= 1'b0;
      dir     <= 1'b0;
      start   <= '0;
      rem     <= '0;
      result  <= '0;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      done_a  <= 1'b0;
      done_b  <= 1'b0;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= state == DONE && !owner_b;
      done_b <= state == DONE && owner_b;
      case (state)
        IDLE: if (bus.req_a || bus.req_b) begin
          owner_b <= pick_b;
          prio_b  <= ~pick_b;
          gnt_a   <= ~pick_b;
          gnt_b   <= pick_b;
          dir     <= pick_b ? bus.dir_b : bus.dir_a;
          start   <= pick_b ? bus.start_b : bus.start_a;
          rem     <= pick_b ? bus.steps_b : bus.steps_a;
          state   <= LOAD;
        end
        LOAD: state <= rem != '0 ? RUN : DONE;
        RUN: begin
          rem <= rem - 1'b1;
          if (rem == WIDTH'(1)) state <= DONE;
        end
        default: begin
          result <= bus.cnt_value;
          state  <= IDLE;
        end
      endcase
    end
  assign bus.gnt_a       = gnt_a;
  assign bus.gnt_b       = gnt_b;
  assign bus.done_a      = done_a;
  assign bus.done_b      = done_b;
  assign bus.result      = result;
  assign bus.busy        = state != IDLE;
  assign bus.cnt_clr     = state == IDLE || state == DONE;
  assign bus.cnt_load    = state == LOAD;
  assign bus.cnt_up_down = state == RUN && dir;
  assign bus.cnt_data    = start;
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: randomized and directed checks of counter_scheduler against a job-level model.
module tb_counter_scheduler;
  localparam int W = 4;
  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] cnt;
  int compared = 0;
  int mismatched = 0;
  counter_scheduler_if #(.WIDTH(W)) bus ();
  counter_scheduler #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // shared counter: clear > load > up/down on every edge
  always @(posedge clk)
    cnt <= bus.cnt_clr ? '0 : bus.cnt_load ? bus.cnt_data : bus.cnt_up_down ? cnt + 1'b1 : cnt - 1'b1;
  assign bus.cnt_value = cnt;

  function automatic int exp_res(input bit d, input int st, input int sp);
    return (st + (d ? sp : -sp)) & ((1 << W) - 1);
  endfunction

  task automatic run_job(input bit b, input bit d, input int st, input int sp, output bit gnt_ok,
                         output int lat, output int res, output logic [2:0] ctl, output int dat,
                         output bit extra);
    if (b) begin
      bus.dir_b = d; bus.start_b = W'(st); bus.steps_b = W'(sp); bus.req_b = 1'b1;
    end else begin
      bus.dir_a = d; bus.start_a = W'(st); bus.steps_a = W'(sp); bus.req_a = 1'b1;
    end
    @(negedge clk);
    gnt_ok = b ? (bus.gnt_b && !bus.gnt_a) : (bus.gnt_a && !bus.gnt_b);
    ctl = {bus.cnt_load, bus.cnt_up_down, bus.cnt_clr};
    dat = int'(bus.cnt_data);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (b ? bus.done_b : bus.done_a) lat = i;
    end
    res = int'(bus.result);
    @(negedge clk);
    extra = b ? bus.done_b : bus.done_a;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared += 3;
    if ({bus.busy, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.cnt_clr, bus.cnt_load, bus.cnt_up_down} !== 8'b0000_0100) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b expected 00000100",
               {bus.busy, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.cnt_clr, bus.cnt_load, bus.cnt_up_down});
    end
    if (bus.result !== '0) begin mismatched++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
    if (bus.cnt_data !== '0) begin mismatched++; $display("FAIL reset_cnt_data: got %0d expected 0", bus.cnt_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    int jobs [4][4] = '{'{0, 1, 3, 5}, '{1, 0, 2, 4}, '{0, 1, 14, 3}, '{0, 1, 9, 0}};
    bit g, x;
    int lat, res, dat;
    logic [2:0] ctl;
    for (int j = 0; j < 4; j++) begin
      run_job(jobs[j][0] != 0, jobs[j][1] != 0, jobs[j][2], jobs[j][3], g, lat, res, ctl, dat, x);
      compared += 6;
      if (g !== 1'b1) begin mismatched++; $display("FAIL vec%0d_gnt: got %0d expected 1", j, g); end
      if (lat !== jobs[j][3] + 2) begin mismatched++; $display("FAIL vec%0d_latency: got %0d expected %0d", j, lat, jobs[j][3] + 2); end
      if (res !== exp_res(jobs[j][1] != 0, jobs[j][2], jobs[j][3])) begin
        mismatched++;
        $display("FAIL vec%0d_result: got %0d expected %0d", j, res, exp_res(jobs[j][1] != 0, jobs[j][2], jobs[j][3]));
      end
      if (ctl !== 3'b100) begin mismatched++; $display("FAIL vec%0d_load_ctl: got %b expected 100", j, ctl); end
      if (dat !== jobs[j][2]) begin mismatched++; $display("FAIL vec%0d_cnt_data: got %0d expected %0d", j, dat, jobs[j][2]); end
      if (x !== 1'b0) begin mismatched++; $display("FAIL vec%0d_done_width: got %0d expected 0", j, x); end
    end
  endtask

  task automatic test_round_robin();
    bit last_b = 1'b1;
    bit want_b, both = 1'b0;
    int grants = 0;
    bus.dir_a = 1'b1; bus.start_a = 4'd1; bus.steps_a = 4'd1;
    bus.dir_b = 1'b0; bus.start_b = 4'd6; bus.steps_b = 4'd2;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 80 && grants < 3; i++) begin
      @(negedge clk);
      if (bus.gnt_a && bus.gnt_b) both = 1'b1;
      if (bus.gnt_a || bus.gnt_b) begin
        want_b = ~last_b;
        compared++;
        if (bus.gnt_b !== want_b) begin mismatched++; $display("FAIL rr_grant%0d: got b=%0d expected b=%0d", grants, bus.gnt_b, want_b); end
        last_b = want_b;
        grants++;
      end
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    compared += 2;
    if (grants !== 3) begin mismatched++; $display("FAIL rr_grant_count: got %0d expected 3", grants); end
    if (both !== 1'b0) begin mismatched++; $display("FAIL rr_double_grant: got %0d expected 0", both); end
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_withdraw_back_to_back();
    bit saw_b = 1'b0, done_seen = 1'b0;
    bus.dir_a = 1'b1; bus.start_a = 4'd4; bus.steps_a = 4'd3; bus.req_a = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.gnt_a !== 1'b1) begin mismatched++; $display("FAIL b2b_gnt_a: got %0d expected 1", bus.gnt_a); end
    bus.req_a = 1'b0;
    @(negedge clk);
    bus.req_b = 1'b1; bus.dir_b = 1'b0; bus.start_b = 4'd0; bus.steps_b = 4'd9;
    @(negedge clk);
    bus.req_b = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      if (bus.gnt_b) saw_b = 1'b1;
      if (bus.done_a) done_seen = 1'b1; else @(negedge clk);
    end
    compared += 2;
    if (saw_b !== 1'b0) begin mismatched++; $display("FAIL withdraw_gnt_b: got %0d expected 0", saw_b); end
    if (done_seen !== 1'b1) begin mismatched++; $display("FAIL b2b_done_a: got %0d expected 1", done_seen); end
    bus.req_b = 1'b1; bus.dir_b = 1'b1; bus.start_b = 4'd7; bus.steps_b = 4'd2;
    @(negedge clk);
    compared++;
    if (bus.gnt_b !== 1'b1) begin mismatched++; $display("FAIL b2b_gnt_b: got %0d expected 1", bus.gnt_b); end
    bus.req_b = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 20 && !done_seen; i++) begin
      @(negedge clk);
      if (bus.done_b) done_seen = 1'b1;
    end
    compared++;
    if (bus.result !== W'(exp_res(1'b1, 7, 2))) begin mismatched++; $display("FAIL b2b_result: got %0d expected %0d", bus.result, exp_res(1'b1, 7, 2)); end
    @(negedge clk);
  endtask

  task automatic test_reset_midjob();
    bit stray = 1'b0, g, x;
    int lat, res, dat;
    logic [2:0] ctl;
    bus.dir_a = 1'b1; bus.start_a = 4'd2; bus.steps_a = 4'd12; bus.req_a = 1'b1;
    @(negedge clk);
    bus.req_a = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    compared += 3;
    if ({bus.busy, bus.cnt_clr, bus.cnt_load, bus.cnt_up_down} !== 4'b0100) begin
      mismatched++;
      $display("FAIL midreset_ctrl: got %b expected 0100", {bus.busy, bus.cnt_clr, bus.cnt_load, bus.cnt_up_down});
    end
    if (bus.result !== '0) begin mismatched++; $display("FAIL midreset_result: got %0d expected 0", bus.result); end
    if (bus.cnt_data !== '0) begin mismatched++; $display("FAIL midreset_cnt_data: got %0d expected 0", bus.cnt_data); end
    repeat (2) @(negedge clk);
    compared++;
    if (cnt !== '0) begin mismatched++; $display("FAIL midreset_counter: got %0d expected 0", cnt); end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done_a || bus.done_b || bus.busy) stray = 1'b1;
    end
    compared++;
    if (stray !== 1'b0) begin mismatched++; $display("FAIL midreset_stray: got %0d expected 0", stray); end
    run_job(1'b0, 1'b0, 5, 6, g, lat, res, ctl, dat, x);
    compared += 3;
    if (g !== 1'b1) begin mismatched++; $display("FAIL postreset_gnt: got %0d expected 1", g); end
    if (lat !== 8) begin mismatched++; $display("FAIL postreset_latency: got %0d expected 8", lat); end
    if (res !== exp_res(1'b0, 5, 6)) begin mismatched++; $display("FAIL postreset_result: got %0d expected %0d", res, exp_res(1'b0, 5, 6)); end
  endtask

  task automatic test_random();
    bit b, d, g, x;
    int st, sp, lat, res, dat;
    logic [2:0] ctl;
    for (int n = 0; n < 25; n++) begin
      b = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      st = int'($urandom_range(0, (1 << W) - 1));
      sp = int'($urandom_range(0, (1 << W) - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_job(b, d, st, sp, g, lat, res, ctl, dat, x);
      compared += 4;
      if (g !== 1'b1) begin mismatched++; $display("FAIL rand%0d_gnt: got %0d expected 1", n, g); end
      if (lat !== sp + 2) begin mismatched++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, sp + 2); end
      if (res !== exp_res(d, st, sp)) begin mismatched++; $display("FAIL rand%0d_result: got %0d expected %0d", n, res, exp_res(d, st, sp)); end
      if (dat !== st) begin mismatched++; $display("FAIL rand%0d_cnt_data: got %0d expected %0d", n, dat, st); end
    end
  endtask

  initial begin
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.dir_a = 1'b0; bus.dir_b = 1'b0;
    bus.start_a = '0; bus.start_b = '0; bus.steps_a = '0; bus.steps_b = '0;
    test_reset();
    test_vectors();
    test_round_robin();
    test_withdraw_back_to_back();
    test_reset_midjob();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
